// File: rtl/ahb_timer_array.sv
// ahb_timer_array: multi-channel AHB-Lite timer peripheral, zero-wait-state slave.
// Each channel has a prescaler, a loadable up-counter, a compare register with
// optional auto-reload, sticky W1C status flags and a registered interrupt.
// Optional feature macro: TIMER_CAPTURE_EN adds capture_i, the CAPTURE register
// and the CAP status flag.
module ahb_timer_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic [NUM_CH-1:0] capture_i
`endif
);

  localparam logic [2:0] R_CTRL    = 3'd0;
  localparam logic [2:0] R_COUNT   = 3'd1;
  localparam logic [2:0] R_COMPARE = 3'd2;
  localparam logic [2:0] R_STATUS  = 3'd3;
`ifdef TIMER_CAPTURE_EN
  localparam logic [2:0] R_CAPTURE = 3'd4;
`endif

  // CTRL keeps only EN, AUTO_RELOAD, IRQ_EN and the PRESCALE field.
  localparam logic [31:0] CTRL_MASK = 32'h0000_0007 | (((32'd1 << PRE_W) - 32'd1) << 8);

  // AHB little-endian byte lanes expanded to a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      3'd0:    be = 4'b0001 << a;
      3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [31:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  // Latched address phase
  logic        dph_q, dph_d;
  logic        dwr_q, dwr_d;
  logic [7:0]  dad_q, dad_d;
  logic [2:0]  dsz_q, dsz_d;

  // Per-channel state
  logic [31:0]       ctrl_q  [NUM_CH];
  logic [31:0]       ctrl_d  [NUM_CH];
  logic [PRE_W-1:0]  pcnt_q  [NUM_CH];
  logic [PRE_W-1:0]  pcnt_d  [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic [CNT_W-1:0]  cmp_q   [NUM_CH];
  logic [CNT_W-1:0]  cmp_d   [NUM_CH];
  logic [NUM_CH-1:0] match_q, match_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] irq_q, irq_d;
  logic [NUM_CH-1:0] cap_flag;

`ifdef TIMER_CAPTURE_EN
  logic [CNT_W-1:0]  capt_q  [NUM_CH];
  logic [CNT_W-1:0]  capt_d  [NUM_CH];
  logic [NUM_CH-1:0] cap_q, cap_d;
  logic [NUM_CH-1:0] cprev_q;
  assign cap_flag = cap_q;
`else
  assign cap_flag = '0;
`endif

  logic [2:0]  d_ch;
  logic [2:0]  d_reg;
  logic [31:0] wmask;
  logic        wr_act;
  logic        unused_bits;

  assign d_ch        = dad_q[7:5];
  assign d_reg       = dad_q[4:2];
  assign wmask       = lane_mask(dsz_q, dad_q[1:0]);
  assign wr_act      = dph_q & dwr_q & HREADY;
  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign irq         = irq_q;
  assign irq_any     = |irq_q;
  assign unused_bits = ^{HADDR[31:8], HTRANS[0]};

  // Capture the address phase of an accepted transfer for use in the data phase.
  always_comb begin
    dph_d = dph_q;
    dwr_d = dwr_q;
    dad_d = dad_q;
    dsz_d = dsz_q;
    if (HREADY) begin
      dph_d = HSEL & HTRANS[1];
      dwr_d = HWRITE;
      dad_d = HADDR[7:0];
      dsz_d = HSIZE;
    end
  end

  // Bus pipeline register; reset abandons any transfer in flight.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dph_q <= 1'b0;
      dwr_q <= 1'b0;
      dad_q <= '0;
      dsz_q <= '0;
    end else begin
      dph_q <= dph_d;
      dwr_q <= dwr_d;
      dad_q <= dad_d;
      dsz_q <= dsz_d;
    end
  end

  // Per-channel next state: bus writes, prescaler, counter, flags and irq.
  always_comb begin
    logic wr_ch, tick, set_match, set_ovf, st_wr;
`ifdef TIMER_CAPTURE_EN
    logic rise;
    rise = 1'b0;
`endif
    wr_ch     = 1'b0;
    tick      = 1'b0;
    set_match = 1'b0;
    set_ovf   = 1'b0;
    st_wr     = 1'b0;
    match_d   = match_q;
    ovf_d     = ovf_q;
    irq_d     = irq_q;
`ifdef TIMER_CAPTURE_EN
    cap_d     = cap_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_d[c]  = ctrl_q[c];
      pcnt_d[c]  = pcnt_q[c];
      count_d[c] = count_q[c];
      cmp_d[c]   = cmp_q[c];
`ifdef TIMER_CAPTURE_EN
      capt_d[c]  = capt_q[c];
`endif
      set_match  = 1'b0;
      set_ovf    = 1'b0;
      wr_ch      = wr_act & (d_ch == 3'(c));
      st_wr      = wr_ch & (d_reg == R_STATUS);
      tick       = ctrl_q[c][0] & (pcnt_q[c] == ctrl_q[c][8 +: PRE_W]);

      // irq follows the flags with one cycle of delay
      irq_d[c] = ctrl_q[c][2] & (match_q[c] | ovf_q[c] | cap_flag[c]);

      if (wr_ch && d_reg == R_CTRL) begin
        ctrl_d[c] = wr_merge(ctrl_q[c], HWDATA, wmask) & CTRL_MASK;
        pcnt_d[c] = '0;
      end else if (ctrl_q[c][0]) begin
        pcnt_d[c] = tick ? '0 : pcnt_q[c] + PRE_W'(1);
      end

      if (wr_ch && d_reg == R_COMPARE)
        cmp_d[c] = CNT_W'(wr_merge(32'(cmp_q[c]), HWDATA, wmask));

      // A software COUNT load beats a tick in the same cycle and raises no flags.
      if (wr_ch && d_reg == R_COUNT) begin
        count_d[c] = CNT_W'(wr_merge(32'(count_q[c]), HWDATA, wmask));
      end else if (tick) begin
        set_match = (count_q[c] == cmp_q[c]);
        if (set_match && ctrl_q[c][1]) begin
          count_d[c] = '0;
        end else begin
          count_d[c] = count_q[c] + CNT_W'(1);
          set_ovf    = &count_q[c];
        end
      end

      // Hardware set beats a same-cycle write-1-to-clear.
      match_d[c] = (match_q[c] & ~(st_wr & HWDATA[0] & wmask[0])) | set_match;
      ovf_d[c]   = (ovf_q[c]   & ~(st_wr & HWDATA[1] & wmask[1])) | set_ovf;

`ifdef TIMER_CAPTURE_EN
      rise = capture_i[c] & ~cprev_q[c];
      if (rise) capt_d[c] = count_q[c];
      cap_d[c] = (cap_q[c] & ~(st_wr & HWDATA[2] & wmask[2])) | rise;
`endif
    end
  end

  // Per-channel state registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ctrl_q[c]  <= '0;
        pcnt_q[c]  <= '0;
        count_q[c] <= '0;
        cmp_q[c]   <= '0;
`ifdef TIMER_CAPTURE_EN
        capt_q[c]  <= '0;
`endif
      end
      match_q <= '0;
      ovf_q   <= '0;
      irq_q   <= '0;
`ifdef TIMER_CAPTURE_EN
      cap_q   <= '0;
      cprev_q <= '0;
`endif
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ctrl_q[c]  <= ctrl_d[c];
        pcnt_q[c]  <= pcnt_d[c];
        count_q[c] <= count_d[c];
        cmp_q[c]   <= cmp_d[c];
`ifdef TIMER_CAPTURE_EN
        capt_q[c]  <= capt_d[c];
`endif
      end
      match_q <= match_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
`ifdef TIMER_CAPTURE_EN
      cap_q   <= cap_d;
      cprev_q <= capture_i;
`endif
    end
  end

  // Read data mux: unmapped registers and absent channels read as zero.
  always_comb begin
    HRDATA = '0;
    if (dph_q && !dwr_q) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (d_ch == 3'(c)) begin
          case (d_reg)
            R_CTRL:    HRDATA = ctrl_q[c];
            R_COUNT:   HRDATA = 32'(count_q[c]);
            R_COMPARE: HRDATA = 32'(cmp_q[c]);
            R_STATUS:  HRDATA = {29'd0, cap_flag[c], ovf_q[c], match_q[c]};
`ifdef TIMER_CAPTURE_EN
            R_CAPTURE: HRDATA = 32'(capt_q[c]);
`endif
            default:   HRDATA = '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_timer_array.sv
// Testbench for ahb_timer_array: directed scenarios plus random bus traffic,
// checked against a cycle-level behavioural model of the register map.
module tb_ahb_timer_array;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PRE_W  = 8;
  localparam logic [31:0] CMASK     = 32'h0000_FFFF;
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

  logic              HCLK    = 1'b0;
  logic              HRESETn = 1'b0;
  logic              HSEL    = 1'b0;
  logic              HREADY  = 1'b1;
  logic [1:0]        HTRANS  = 2'b00;
  logic [31:0]       HADDR   = '0;
  logic              HWRITE  = 1'b0;
  logic [2:0]        HSIZE   = 3'd0;
  logic [31:0]       HWDATA  = '0;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;
`ifdef TIMER_CAPTURE_EN
  logic [NUM_CH-1:0] capture_i = '0;
`endif

  always #5 HCLK = ~HCLK;

  ahb_timer_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .irq(irq), .irq_any(irq_any)
`ifdef TIMER_CAPTURE_EN
    , .capture_i(capture_i)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_ctrl [NUM_CH];
  logic [31:0] m_cnt  [NUM_CH];
  logic [31:0] m_cmp  [NUM_CH];
  logic [31:0] m_capt [NUM_CH];
  int          m_pre  [NUM_CH];
  bit          m_match[NUM_CH];
  bit          m_ovf  [NUM_CH];
  bit          m_cap  [NUM_CH];
  bit          m_irq  [NUM_CH];
  bit          m_prev [NUM_CH];
  bit          ph_v = 1'b0;
  bit          ph_wr = 1'b0;
  logic [7:0]  ph_addr = '0;
  logic [2:0]  ph_size = '0;
  logic [31:0] seq [16];

  // Advance the model across one rising edge using the inputs currently driven.
  function automatic void model_edge();
    logic [31:0] mask, clr, nc, newv;
    int n, lo, ch, rg, ps;
    bit wc, en, ar, ie, tick, sm, so, wr;
    if (!HRESETn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_ctrl[c] = 0; m_cnt[c] = 0; m_cmp[c] = 0; m_capt[c] = 0; m_pre[c] = 0;
        m_match[c] = 0; m_ovf[c] = 0; m_cap[c] = 0; m_irq[c] = 0; m_prev[c] = 0;
      end
      ph_v = 0;
      return;
    end
    n    = (ph_size >= 3'd2) ? 4 : (1 << ph_size);
    lo   = int'(ph_addr[1:0]) & ~(n - 1);
    mask = '0;
    for (int b = 0; b < 4; b++)
      if (b >= lo && b < lo + n) mask[8*b +: 8] = 8'hFF;
    wc = ph_v && ph_wr;
    ch = int'(ph_addr[7:5]);
    rg = int'(ph_addr[4:2]);
    for (int c = 0; c < NUM_CH; c++) begin
      wr   = wc && (ch == c);
      en   = m_ctrl[c][0];
      ar   = m_ctrl[c][1];
      ie   = m_ctrl[c][2];
      ps   = int'((m_ctrl[c] >> 8) & 32'hFF);
      m_irq[c] = ie && (m_match[c] || m_ovf[c] || m_cap[c]);
      tick = en && (m_pre[c] == ps);
      sm = 0; so = 0;
      nc = m_cnt[c];
      if (wr && rg == 1) begin
        nc = ((m_cnt[c] & ~mask) | (HWDATA & mask)) & CMASK;
      end else if (tick) begin
        sm = (m_cnt[c] == m_cmp[c]);
        if (sm && ar) nc = 0;
        else begin
          nc = (m_cnt[c] + 1) & CMASK;
          so = (m_cnt[c] == CMASK);
        end
      end
      clr = (wr && rg == 3) ? (HWDATA & mask) : 32'd0;
`ifdef TIMER_CAPTURE_EN
      if (capture_i[c] && !m_prev[c]) begin
        m_capt[c] = m_cnt[c];
        m_cap[c]  = 1;
      end else if (clr[2]) begin
        m_cap[c] = 0;
      end
      m_prev[c] = capture_i[c];
`endif
      m_match[c] = (m_match[c] && !clr[0]) || sm;
      m_ovf[c]   = (m_ovf[c] && !clr[1]) || so;
      if (wr && rg == 0) m_pre[c] = 0;
      else if (en) m_pre[c] = (m_pre[c] + 1) % (ps + 1);
      if (wr && rg == 0) begin
        newv = (m_ctrl[c] & ~mask) | (HWDATA & mask);
        m_ctrl[c] = newv & CTRL_MASK;
      end
      if (wr && rg == 2) begin
        newv = (m_cmp[c] & ~mask) | (HWDATA & mask);
        m_cmp[c] = newv & CMASK;
      end
      m_cnt[c] = nc;
    end
    ph_v    = HSEL && HREADY && HTRANS[1];
    ph_wr   = HWRITE;
    ph_addr = HADDR[7:0];
    ph_size = HSIZE;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int ch, rg;
    ch = int'(a[7:5]);
    rg = int'(a[4:2]);
    if (ch >= NUM_CH) return 32'd0;
    case (rg)
      0: return m_ctrl[ch];
      1: return m_cnt[ch];
      2: return m_cmp[ch];
      3: return {29'd0, m_cap[ch], m_ovf[ch], m_match[ch]};
`ifdef TIMER_CAPTURE_EN
      4: return m_capt[ch];
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_irqv();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_irq[c];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge HCLK);
    #1;
    chk("irq", 32'(irq), m_irqv());
    chk("irq_any", 32'(irq_any), 32'(m_irqv() != 0));
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    addr_phase(a, 1'b1, sz);
    step();
    idle();
    HWDATA = d;
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, output logic [31:0] v);
    addr_phase(a, 1'b0, 3'd2);
    step();
    idle();
    chk(tag, HRDATA, model_read(a));
    v = HRDATA;
    step();
  endtask

  // Word write immediately followed by back-to-back reads of raddr.
  task automatic wr_then_stream(input logic [31:0] wa, input logic [31:0] wd,
                                input logic [31:0] ra, input int n);
    addr_phase(wa, 1'b1, 3'd2);
    step();
    HWDATA = wd;
    addr_phase(ra, 1'b0, 3'd2);
    step();
    for (int i = 0; i < n; i++) begin
      chk("stream", HRDATA, model_read(ra));
      seq[i] = HRDATA;
      if (i == n - 1) idle();
      step();
    end
  endtask

  initial begin
    logic [31:0] v, a, d;
    int ch, rg, sz;

    // Reset held for two cycles
    HRESETn = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < 8; r++) begin
        rd_chk("reset_reg", 32'(c * 32 + r * 4), v);
        chk("reset_zero", v, 32'd0);
      end
    chk("hreadyout", 32'(HREADYOUT), 32'd1);
    chk("hresp", 32'(HRESP), 32'd0);
    chk("irq_reset", 32'(irq), 32'd0);

    // Compare with auto-reload on ch0
    wr(32'h08, 32'd3, 3'd2);
    wr_then_stream(32'h00, 32'h7, 32'h04, 6);
    chk("ar_seq0", seq[0], 32'd0);
    chk("ar_seq1", seq[1], 32'd1);
    chk("ar_seq2", seq[2], 32'd2);
    chk("ar_seq3", seq[3], 32'd3);
    chk("ar_seq4", seq[4], 32'd0);
    rd_chk("ar_status", 32'h0C, v);
    chk("ar_match", v & 32'd1, 32'd1);
    chk("ar_irq", 32'(irq[0]), 32'd1);
    wr(32'h00, 32'h6, 3'd2);
    wr(32'h0C, 32'h1, 3'd2);
    step();
    chk("irq_cleared", 32'(irq[0]), 32'd0);

    // Overflow through the prescaler on ch1
    wr(32'h24, 32'hFFFE, 3'd2);
    wr_then_stream(32'h20, 32'h201, 32'h24, 8);
    chk("ovf_seq0", seq[0], 32'hFFFE);
    chk("ovf_seq2", seq[2], 32'hFFFE);
    chk("ovf_seq3", seq[3], 32'hFFFF);
    chk("ovf_seq5", seq[5], 32'hFFFF);
    chk("ovf_seq6", seq[6], 32'h0000);
    rd_chk("ovf_status", 32'h2C, v);
    chk("ovf_flag", v & 32'd2, 32'd2);
    wr(32'h20, 32'h0, 3'd2);

    // Byte write to COMPARE byte 1 on ch2
    wr(32'h49, 32'h0000_5500, 3'd0);
    rd_chk("byte_rd", 32'h48, v);
    chk("byte_val", v, 32'h0000_5500);
    wr(32'h4A, 32'hABCD_0000, 3'd1);
    rd_chk("half_hi_rd", 32'h48, v);
    chk("half_hi_val", v, 32'h0000_5500);

    // COUNT write on a tick cycle loads the written value
    wr(32'h40, 32'h1, 3'd2);
    wr_then_stream(32'h44, 32'h100, 32'h44, 3);
    chk("load_tick0", seq[0], 32'h100);
    chk("load_tick1", seq[1], 32'h101);
    wr(32'h40, 32'h0, 3'd2);
    wr(32'h4C, 32'h7, 3'd2);

    // W1C landing on the same edge as a MATCH set
    wr(32'h44, 32'h10, 3'd2);
    wr(32'h48, 32'h12, 3'd2);
    wr(32'h40, 32'h1, 3'd2);
    step();
    wr(32'h4C, 32'h1, 3'd2);
    rd_chk("w1c_race_rd", 32'h4C, v);
    chk("w1c_race_match", v & 32'd1, 32'd1);
    wr(32'h40, 32'h0, 3'd2);

`ifdef TIMER_CAPTURE_EN
    // Capture on ch3 with a frozen counter
    wr(32'h64, 32'h10, 3'd2);
    capture_i[3] = 1'b1;
    step();
    capture_i[3] = 1'b0;
    step();
    rd_chk("cap_rd", 32'h70, v);
    chk("cap_val", v, 32'h10);
    rd_chk("cap_status", 32'h6C, v);
    chk("cap_flag", v & 32'd4, 32'd4);
    wr(32'h64, 32'h20, 3'd2);
    capture_i[3] = 1'b1;
    step();
    step();
    wr(32'h64, 32'h30, 3'd2);
    step();
    rd_chk("cap_held_rd", 32'h70, v);
    chk("cap_held_val", v, 32'h20);
    capture_i[3] = 1'b0;
`else
    rd_chk("nocap_rd", 32'h70, v);
    chk("nocap_val", v, 32'd0);
`endif

    // Out-of-range channel and unmapped register
    wr(32'h88, 32'h0000_ABCD, 3'd2);
    rd_chk("oor_rd", 32'h88, v);
    chk("oor_val", v, 32'd0);
    chk("oor_hresp", 32'(HRESP), 32'd0);
    wr(32'h14, 32'h1234, 3'd2);
    rd_chk("unmapped_rd", 32'h14, v);
    chk("unmapped_val", v, 32'd0);

    // Random register traffic
    for (int i = 0; i < 300; i++) begin
      ch = $urandom_range(0, 4);
      rg = $urandom_range(0, 7);
      sz = $urandom_range(0, 2);
      a  = {24'd0, 3'(ch), 3'(rg), 2'b00};
      if (sz == 0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 1) a[1] = 1'($urandom_range(0, 1));
      d = $urandom;
      if (rg == 0) d = d & 32'h0000_0707;
      if ((rg == 1 || rg == 2) && $urandom_range(0, 3) != 0) d = d & 32'h1F;
`ifdef TIMER_CAPTURE_EN
      capture_i = NUM_CH'($urandom);
`endif
      if ($urandom_range(0, 1) == 1) wr(a, d, 3'(sz));
      else rd_chk("rand_rd", a, v);
    end
`ifdef TIMER_CAPTURE_EN
    capture_i = '0;
`endif

    // Reset during a write data phase abandons the write
    wr(32'h00, 32'h0, 3'd2);
    addr_phase(32'h08, 1'b1, 3'd2);
    step();
    idle();
    HWDATA  = 32'h77;
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    rd_chk("rst_mid_rd", 32'h08, v);
    chk("rst_mid_val", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
